// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    // Bit positions inside the 4-bit NZCV flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, then trial-subtract the divisor.
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_divisor,
    input  logic         i_bit,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    // The shifted remainder keeps its top bit: with a divisor above 2^(N-1)
    // the partial remainder can need N+1 bits before the subtraction.
    logic [N:0]   w_shift;
    logic [N+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};

    // Extra MSB of the difference acts as the borrow (shift < divisor)
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit  = ~w_diff[N+1];

    // When no subtraction happens, shift < divisor so it fits in N bits
    assign o_rem   = o_qbit ? w_diff[N-1:0] : w_shift[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned,
// with divide-by-zero and signed-overflow trapping and NZCV flag output.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic [3:0]   flags
);

    localparam int           CW    = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0] W_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] W_ONE = {{(N-1){1'b0}}, 1'b1};

    div_state_t    r_state;
    logic          r_sgn, r_sa, r_sb, r_div0;
    logic [N-1:0]  r_dvd, r_dvs, r_araw, r_rem, r_quo;
    logic [CW-1:0] r_cnt;
    logic          r_busy, r_done;
    logic [N-1:0]  r_q, r_r;
    logic [3:0]    r_flags;

    logic          w_a_neg, w_b_neg;
    logic [N-1:0]  w_a_mag, w_b_mag;
    logic [N-1:0]  w_rem_nxt;
    logic          w_qbit;
    logic          w_ovf;
    logic [N-1:0]  w_q_fin, w_r_fin;
    logic [3:0]    w_flags_fin;

    // Operand magnitudes; -2^(N-1) maps onto its unsigned N-bit magnitude
    assign w_a_neg = is_signed & a[N-1];
    assign w_b_neg = is_signed & b[N-1];
    assign w_a_mag = w_a_neg ? (~a + W_ONE) : a;
    assign w_b_mag = w_b_neg ? (~b + W_ONE) : b;

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_dvs),
        .i_bit     (r_dvd[r_cnt]),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // The only signed case whose magnitude quotient does not fit: -2^(N-1) / -1
    assign w_ovf = r_sgn & r_sa & r_sb & (r_dvd == W_MIN) & (r_dvs == W_ONE);

    // Final result: sign correction, div-by-zero substitution and flags
    always_comb begin
        w_q_fin     = r_quo;
        w_r_fin     = r_rem;
        w_flags_fin = '0;
        if (r_div0) begin
            w_q_fin = '1;
            w_r_fin = r_araw;
        end else begin
            if (r_sa ^ r_sb) w_q_fin = ~r_quo + W_ONE;
            if (r_sa)        w_r_fin = ~r_rem + W_ONE;
        end
        w_flags_fin[FLAG_N] = w_q_fin[N-1];
        w_flags_fin[FLAG_Z] = (w_q_fin == '0);
        w_flags_fin[FLAG_C] = 1'b0;
        w_flags_fin[FLAG_V] = r_div0 | w_ovf;
    end

    // Control FSM with registered busy/done and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sgn   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_div0  <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_araw  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sgn  <= is_signed;
                        r_sa   <= w_a_neg;
                        r_sb   <= w_b_neg;
                        r_dvd  <= w_a_mag;
                        r_dvs  <= w_b_mag;
                        r_araw <= a;
                        r_rem  <= '0;
                        r_quo  <= '0;
                        r_cnt  <= CW'(N-1);
                        r_busy <= 1'b1;
                        r_div0 <= (b == '0);
                        r_state <= (b == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[N-2:0], w_qbit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= FIN;
                end
                FIN: begin
                    r_q     <= w_q_fin;
                    r_r     <= w_r_fin;
                    r_flags <= w_flags_fin;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign q     = r_q;
    assign r     = r_r;
    assign flags = r_flags;

endmodule
